load_store_unit: RTL and testbench

- Memory stage of the multicycle RV32I core. Sits directly downstream of the control FSM/ALU.
- Takes an effective address from the ALU plus the load/store funct3 from the decoder. Drives the on-chip data memory and returns a formatted load value or a store completion to the control FSM for writeback.
- Handles RV32I byte/half/word sizing, byte-lane steering, sign/zero extension, memory read latency, and access faults.

---
 rtl/load_store_unit_pkg.sv | 24 ++
 rtl/lsu_lane_fmt.sv | 58 +++++
 rtl/load_store_unit.sv | 148 ++++++++++++++
 tb/tb_load_store_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared RV32I load/store definitions: opcodes, funct3 sizes and LSU FSM state encodings.
package load_store_unit_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD_WAIT = 2'd1,
    S_STORE     = 2'd2,
    S_RESP      = 2'd3
  } lsu_state_e;

  function automatic logic is_lsu_opcode(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Byte-lane steering for stores and lane extract plus sign/zero extension for loads.
module lsu_lane_fmt
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_byteena,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_byteena = 4'b0000;
    st_wdata   = 32'h0;
    case (st_funct3)
      F3_B: begin
        st_byteena = 4'b0001 << st_off;
        st_wdata   = {4{st_data[7:0]}};
      end
      F3_H: begin
        st_byteena = 4'b0011 << st_off;
        st_wdata   = {2{st_data[15:0]}};
      end
      F3_W: begin
        st_byteena = 4'b1111;
        st_wdata   = st_data;
      end
      default: ;
    endcase
  end

  // Offsets arrive already aligned, so the half select only needs bit 1.
  always_comb begin
    byte_sh = ld_raw >> {ld_off, 3'b000};
    half_sh = ld_raw >> {ld_off[1], 4'b0000};
    ld_byte = byte_sh[7:0];
    ld_half = half_sh[15:0];
    ld_data = 32'h0;
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_W:    ld_data = ld_raw;
      F3_BU:   ld_data = {24'h0, ld_byte};
      F3_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: sizing, lane steering, latency wait and fault checks.
// Define LSU_MISALIGN_TRAP_EN to fault on misaligned half/word instead of force-aligning.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_byteena,
  output logic              mem_wren,
  input  logic [31:0]       mem_q
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // resp_valid is a single-cycle pulse with resp_rdata/resp_err valid alongside it.

  lsu_state_e state, next_state;

  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [3:0]        be_q;
  logic [31:0]       wd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [2:0]        cnt_q;

  logic        accept, fault, illegal, out_of_range, misaligned, cnt_last;
  logic [1:0]  off_aligned;
  logic [3:0]  st_be;
  logic [31:0] st_wd, ld_fmt;

  assign accept   = (state == S_IDLE) && req_valid;
  assign cnt_last = (cnt_q == 3'd1);

  always_comb begin
    if (req_store)
      illegal = !(req_funct3 inside {F3_B, F3_H, F3_W});
    else
      illegal = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    out_of_range = |req_addr[31:ADDR_W+2];
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]) ||
                 ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
    fault = illegal || out_of_range || misaligned;
  end

  // Natural alignment is applied unconditionally; in the trapping build any
  // access it would change has already been faulted.
  always_comb begin
    case (req_funct3)
      F3_H, F3_HU: off_aligned = {req_addr[1], 1'b0};
      F3_W:        off_aligned = 2'b00;
      default:     off_aligned = req_addr[1:0];
    endcase
  end

  lsu_lane_fmt u_lane_fmt (
    .st_funct3  (req_funct3),
    .st_off     (off_aligned),
    .st_data    (req_wdata),
    .st_byteena (st_be),
    .st_wdata   (st_wd),
    .ld_funct3  (f3_q),
    .ld_off     (off_q),
    .ld_raw     (mem_q),
    .ld_data    (ld_fmt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      be_q    <= 4'b0000;
      wd_q    <= 32'h0;
      addr_q  <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= 3'd0;
    end else begin
      state <= next_state;
      if (accept) begin
        f3_q    <= req_funct3;
        off_q   <= off_aligned;
        err_q   <= fault;
        rdata_q <= 32'h0;
        if (!fault) begin
          addr_q <= req_addr[ADDR_W+1:2];
          if (req_store) begin
            be_q <= st_be;
            wd_q <= st_wd;
          end else begin
            cnt_q <= 3'(MEM_LATENCY);
          end
        end
      end else if (state == S_LOAD_WAIT) begin
        cnt_q <= cnt_q - 3'd1;
        if (cnt_last) rdata_q <= ld_fmt;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (fault)          next_state = S_RESP;
          else if (req_store) next_state = S_STORE;
          else                next_state = S_LOAD_WAIT;
        end
      end
      S_LOAD_WAIT: if (cnt_last) next_state = S_RESP;
      S_STORE:     next_state = S_RESP;
      S_RESP:      next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state == S_IDLE);
    resp_valid  = (state == S_RESP);
    resp_err    = (state == S_RESP) && err_q;
    resp_rdata  = rdata_q;
    mem_wren    = (state == S_STORE);
    mem_byteena = (state == S_STORE) ? be_q : 4'b0000;
    mem_addr    = addr_q;
    mem_wdata   = wd_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a one-register-stage data memory model.
module tb_load_store_unit;

  localparam int ADDR_W = 8;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_store;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr, req_wdata;
  logic              resp_valid, resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_q;
  logic [3:0]        mem_byteena;
  logic              mem_wren;

  logic [31:0] mem     [2**ADDR_W];
  logic [31:0] ref_mem [2**ADDR_W];

  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          exp_lat_q[$];

  int errors = 0;
  int checks = 0;

  load_store_unit #(.ADDR_W(ADDR_W), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byteena(mem_byteena),
    .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // Memory: q is one register behind the address, so data for an address
  // presented at one edge is sampled by the unit two edges later.
  always @(posedge clk) begin
    if (mem_wren) begin
      for (int i = 0; i < 4; i++)
        if (mem_byteena[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
    mem_q <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] w,
                                           input logic [1:0] a);
    logic [31:0] t;
    logic [7:0]  b;
    logic [15:0] h;
    t = w >> (8 * a);
    b = t[7:0];
    t = w >> (16 * a[1]);
    h = t[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return w;
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge after the response.
  task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                        input int exp_wren, input logic [3:0] exp_be, input logic [31:0] exp_wd);
    int cyc;
    int wren_cnt;
    bit got;
    exp_q.push_back(exp_rd);
    exp_err_q.push_back(exp_err);
    exp_lat_q.push_back(exp_lat);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 0; wren_cnt = 0; got = 0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (mem_wren) begin
        wren_cnt++;
        chk({tag, "_be"}, 32'(mem_byteena), 32'(exp_be));
        chk({tag, "_wdata"}, mem_wdata, exp_wd);
        chk({tag, "_wren_cyc"}, 32'(cyc), 32'd1);
      end
      if (resp_valid) got = 1;
    end
    if (!got) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front()); void'(exp_err_q.pop_front()); void'(exp_lat_q.pop_front());
    end else begin
      chk({tag, "_rdata"}, resp_rdata, exp_q.pop_front());
      chk({tag, "_err"}, 32'(resp_err), 32'(exp_err_q.pop_front()));
      chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat_q.pop_front()));
    end
    chk({tag, "_wren_cnt"}, 32'(wren_cnt), 32'(exp_wren));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(resp_valid), 32'd0);
  endtask

  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] w;
    w = ref_mem[addr[ADDR_W+1:2]];
    do_req(tag, 1'b0, f3, addr, 32'h0, exp_load(f3, w, addr[1:0]), 1'b0, LAT + 1,
           0, 4'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    mem[4] = 32'h808182F3;
    ref_mem[4] = 32'h808182F3;
    mem_q = 32'h0;
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_wren", 32'(mem_wren), 32'd0);
    chk("rst_be", 32'(mem_byteena), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'h0);

    load("lb10",  3'b000, 32'h10);
    load("lbu13", 3'b100, 32'h13);
    load("lh12",  3'b001, 32'h12);
    load("lhu12", 3'b101, 32'h12);
    load("lw10",  3'b010, 32'h10);
    chk("lb10_const", exp_load(3'b000, 32'h808182F3, 2'd0), 32'hFFFFFFF3);

    do_req("sb11", 1'b1, 3'b000, 32'h11, 32'h000000AA, 32'h0, 1'b0, 2, 1, 4'b0010, 32'hAAAAAAAA);
    ref_mem[4] = 32'h8081AAF3;
    do_req("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'h8081AAF3, 1'b0, LAT + 1, 0, 4'h0, 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
    do_req("lw12", 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 1, 0, 4'h0, 32'h0);
    do_req("sh11", 1'b1, 3'b001, 32'h11, 32'h1234, 32'h0, 1'b1, 1, 0, 4'h0, 32'h0);
`else
    do_req("lw12", 1'b0, 3'b010, 32'h12, 32'h0, 32'h8081AAF3, 1'b0, LAT + 1, 0, 4'h0, 32'h0);
    do_req("lh13", 1'b0, 3'b001, 32'h13, 32'h0, 32'hFFFF8081, 1'b0, LAT + 1, 0, 4'h0, 32'h0);
`endif
    do_req("lw400", 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1, 1, 0, 4'h0, 32'h0);
    do_req("st011", 1'b1, 3'b011, 32'h20, 32'h55, 32'h0, 1'b1, 1, 0, 4'h0, 32'h0);
    do_req("ld011", 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, 1, 0, 4'h0, 32'h0);
    do_req("sh22", 1'b1, 3'b001, 32'h22, 32'h0000BEEF, 32'h0, 1'b0, 2, 1, 4'b1100, 32'hBEEFBEEF);
    ref_mem[8] = 32'hBEEF0000;
    load("lhu22", 3'b101, 32'h22);

    // Randomised word stores followed by sized loads from the same word.
    for (int n = 0; n < 6; n++) begin
      logic [31:0] a, d;
      logic [2:0]  f3;
      logic [1:0]  off;
      a = 32'($urandom_range(16, 63)) << 2;
      d = $urandom;
      do_req("rsw", 1'b1, 3'b010, a, d, 32'h0, 1'b0, 2, 1, 4'b1111, d);
      ref_mem[a[ADDR_W+1:2]] = d;
      case ($urandom_range(0, 4))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
      off = 2'($urandom_range(0, 3));
      if (f3 == 3'b001 || f3 == 3'b101) off[0] = 1'b0;
      if (f3 == 3'b010) off = 2'b00;
      load("rld", f3, a | 32'(off));
    end

    // Reset in the middle of a load wait.
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_ready", 32'(req_ready), 32'd1);
    chk("mid_valid", 32'(resp_valid), 32'd0);
    chk("mid_wren", 32'(mem_wren), 32'd0);
    do_req("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 32'h8081AAF3, 1'b0, LAT + 1, 0, 4'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
